// File: rtl/stack_pkg.sv
// stack_pkg: stack operation encoding and the push/pop decode shared with the control unit.
package stack_pkg;
   typedef enum logic [1:0] {STACK_OP_NONE, STACK_OP_PUSH, STACK_OP_POP, STACK_OP_REPL} stack_op_e;
   // Returns the operation that actually changes state; error cases decode to NONE.
   function automatic stack_op_e stack_decode(input logic push, input logic pop, input logic empty, input logic full);
      return (push && pop && !empty) ? STACK_OP_REPL :
             (push && !pop && !full) ? STACK_OP_PUSH :
             (pop && !push && !empty) ? STACK_OP_POP : STACK_OP_NONE;
   endfunction
endpackage

// File: rtl/stack_ram.sv
// stack_ram: DEPTH x WIDTH storage, one synchronous write port and one asynchronous read port.
module stack_ram #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end
   assign rdata = mem_q[raddr];
endmodule

// File: rtl/param_stack.sv
// param_stack: LIFO stack with status, sticky errors, replace-top, flush and top-of-stack peek.
module param_stack
   import stack_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 1024,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic             err_clr,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic [WIDTH-1:0] top,
   output logic [AW:0]      count,
   output logic             empty,
   output logic             full,
   output logic             overflow,
   output logic             underflow
);
   logic [AW:0]      sp_q, sp_d;
   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic             overflow_q, overflow_d, underflow_q, underflow_d;
   logic             we;
   logic [AW-1:0]    waddr, raddr;
   logic [WIDTH-1:0] rdata;
   stack_op_e        op;

   assign empty = (sp_q == '0);
   assign full  = (sp_q == (AW+1)'(DEPTH));
   assign raddr = AW'(sp_q - 1'b1);

   stack_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (data_in),
      .raddr (raddr),
      .rdata (rdata)
   );

   always_comb begin
      op          = stack_decode(push, pop, empty, full);
      we          = !flush && (op == STACK_OP_PUSH || op == STACK_OP_REPL);
      waddr       = (op == STACK_OP_REPL) ? raddr : AW'(sp_q);
      sp_d        = flush ? '0 : (op == STACK_OP_PUSH) ? sp_q + 1'b1 : (op == STACK_OP_POP) ? sp_q - 1'b1 : sp_q;
      data_out_d  = (!flush && (op == STACK_OP_POP || op == STACK_OP_REPL)) ? rdata : data_out_q;
      // A new error in the same cycle as err_clr keeps the flag set.
      overflow_d  = (overflow_q && !err_clr) || (!flush && push && !pop && full);
      underflow_d = (underflow_q && !err_clr) || (!flush && pop && empty);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sp_q        <= '0;
         data_out_q  <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         sp_q        <= sp_d;
         data_out_q  <= data_out_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign data_out  = data_out_q;
   assign top       = empty ? '0 : rdata;
   assign count     = sp_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;
endmodule

// File: tb/tb_param_stack.sv
// tb_param_stack: directed stimulus with a queued scoreboard drained by a negedge monitor.
module tb_param_stack;
   logic        clk = 1'b0, reset_n = 1'b0;
   logic        push = 1'b0, pop = 1'b0, flush = 1'b0, err_clr = 1'b0;
   logic [31:0] data_in = '0;
   logic [31:0] do8, top8, do4, top4;
   logic [3:0]  cnt8;
   logic [2:0]  cnt4;
   logic        e8, f8, o8, u8, e4, f4, o4, u4;

   always #5 clk = ~clk;

   param_stack #(.WIDTH(32), .DEPTH(8)) dut8 (
      .clk(clk), .reset_n(reset_n), .push(push), .pop(pop), .flush(flush), .err_clr(err_clr),
      .data_in(data_in), .data_out(do8), .top(top8), .count(cnt8), .empty(e8), .full(f8),
      .overflow(o8), .underflow(u8)
   );
   param_stack #(.WIDTH(32), .DEPTH(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .push(push), .pop(pop), .flush(flush), .err_clr(err_clr),
      .data_in(data_in), .data_out(do4), .top(top4), .count(cnt4), .empty(e4), .full(f4),
      .overflow(o4), .underflow(u4)
   );

   typedef struct {string name; int due; int sel; logic [31:0] exp;} chk_t;
   chk_t sbq[$];
   int   cyc = 0, total = 0, bad = 0;

   localparam int DO8 = 0, TOP8 = 1, CNT8 = 2, E8 = 3, F8 = 4, O8 = 5, U8 = 6;
   localparam int DO4 = 8, TOP4 = 9, CNT4 = 10, E4 = 11, F4 = 12, O4 = 13, U4 = 14;

   function automatic logic [31:0] get(int sel);
      case (sel)
         DO8:  return do8;
         TOP8: return top8;
         CNT8: return 32'(cnt8);
         E8:   return 32'(e8);
         F8:   return 32'(f8);
         O8:   return 32'(o8);
         U8:   return 32'(u8);
         DO4:  return do4;
         TOP4: return top4;
         CNT4: return 32'(cnt4);
         E4:   return 32'(e4);
         F4:   return 32'(f4);
         O4:   return 32'(o4);
         U4:   return 32'(u4);
         default: return 'x;
      endcase
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
         chk_t c;
         c = sbq.pop_front();
         total++;
         if (get(c.sel) !== c.exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", c.name, get(c.sel), c.exp);
         end
      end
   end

   task automatic want_at(string n, int sel, logic [31:0] e, int due);
      chk_t c;
      c.name = n; c.sel = sel; c.exp = e; c.due = due;
      sbq.push_back(c);
   endtask

   task automatic want(string n, int sel, logic [31:0] e);
      want_at(n, sel, e, cyc + 1);
   endtask

   task automatic op(logic pu, logic po, logic fl, logic ec, logic [31:0] d);
      @(negedge clk);
      push = pu; pop = po; flush = fl; err_clr = ec; data_in = d;
   endtask

   initial begin
      want_at("rst_count", CNT8, 0, 0);
      want_at("rst_empty", E8, 1, 0);
      want_at("rst_dout", DO8, 0, 0);
      want_at("rst_ovf", O4, 0, 0);
      @(negedge clk); @(negedge clk);
      reset_n = 1'b1;
      op(1, 0, 0, 0, 10); op(1, 0, 0, 0, 20); op(1, 0, 0, 0, 30); op(1, 0, 0, 0, 40);
      want("full4", F4, 1); want("cnt4_full", CNT4, 4); want("no_ovf_yet", O4, 0); want("top4_40", TOP4, 40);
      op(1, 0, 0, 0, 50);
      want("ovf4", O4, 1); want("top4_hold", TOP4, 40); want("cnt4_hold", CNT4, 4);
      want("cnt8_5", CNT8, 5); want("top8_50", TOP8, 50);
      op(0, 1, 0, 0, 0);
      want("pop_50", DO8, 50); want("cnt8_4", CNT8, 4);
      op(1, 0, 0, 0, 60);
      want("cnt8_5b", CNT8, 5); want("top8_60", TOP8, 60);
      op(0, 0, 0, 0, 0);
      @(posedge clk); #2 reset_n = 1'b0;
      want_at("arst_count", CNT8, 0, cyc); want_at("arst_empty", E8, 1, cyc);
      want_at("arst_dout", DO8, 0, cyc); want_at("arst_ovf", O4, 0, cyc); want_at("arst_top", TOP8, 0, cyc);
      @(negedge clk); @(negedge clk);
      reset_n = 1'b1;
      op(1, 0, 0, 0, 1); op(1, 0, 0, 0, 32'hFFFF_FFFE); op(1, 0, 0, 0, 3);
      want("lifo_top3", TOP8, 3); want("lifo_cnt3", CNT8, 3);
      op(0, 1, 0, 0, 0); want("lifo_pop3", DO8, 3);
      op(0, 1, 0, 0, 0); want("lifo_pop_m2", DO8, 32'hFFFF_FFFE);
      op(0, 1, 0, 0, 0); want("lifo_pop1", DO8, 1); want("lifo_empty", E8, 1);
      want("lifo_cnt0", CNT8, 0); want("empty_top0", TOP8, 0);
      op(0, 0, 0, 0, 0); want("dout_hold_idle", DO8, 1);
      op(0, 1, 0, 0, 0); want("udf_set", U8, 1); want("udf_dout_hold", DO8, 1);
      op(0, 1, 0, 1, 0); want("udf_set_wins", U8, 1);
      op(0, 0, 0, 1, 0); want("udf_clr", U8, 0);
      op(1, 0, 0, 0, 7); op(1, 0, 0, 0, 8);
      op(1, 1, 0, 0, 9);
      want("repl_dout", DO8, 8); want("repl_top", TOP8, 9); want("repl_cnt", CNT8, 2); want("repl_no_ovf", O8, 0);
      op(1, 0, 0, 0, 11); want("pre_flush_cnt", CNT8, 3);
      op(1, 0, 1, 0, 99);
      want("flush_cnt", CNT8, 0); want("flush_empty", E8, 1); want("flush_dout", DO8, 8); want("flush_top", TOP8, 0);
      op(0, 1, 0, 0, 0); want("post_flush_udf", U8, 1); want("post_flush_dout", DO8, 8);
      op(0, 0, 0, 1, 0); want("udf_clr2", U8, 0);
      op(1, 1, 0, 0, 5); want("pp_empty_udf", U8, 1); want("pp_empty_cnt", CNT8, 0); want("pp_empty_top", TOP8, 0);
      op(0, 0, 0, 0, 0);
      @(negedge clk); @(negedge clk); @(negedge clk);
      if (sbq.size() != 0) begin
         total++; bad++;
         $display("FAIL drain: %0d checks left, expected 0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
